// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind a uart_rx: hunts for SYNC, checks LEN and the two's-complement
// checksum, buffers the payload and streams good frames out on a valid/ready port.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         LEN_SIZE       = 5,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         TIMEOUT_SIZE   = 11
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_rx_busy,
    output logic       o_rx_enable,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_last,
    output logic       o_busy,
    output logic       o_frame_ok,
    output logic       o_err_len,
    output logic       o_err_chk,
    output logic       o_err_timeout
);

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHK     = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;

    localparam int                      BUF_DEPTH = 1 << LEN_SIZE;
    localparam logic [LEN_SIZE-1:0]     ONE       = LEN_SIZE'(1);
    localparam logic [7:0]              MAX_LEN_B = 8'(MAX_LEN);
    // Fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
    localparam logic [TIMEOUT_SIZE-1:0] TO_TERM   = TIMEOUT_SIZE'(TIMEOUT_CYCLES - 2);

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic [LEN_SIZE-1:0]     r_len;
    logic [LEN_SIZE-1:0]     r_idx;
    logic [LEN_SIZE-1:0]     r_rd;
    logic [LEN_SIZE-1:0]     w_rd_addr;
    logic [7:0]              r_sum;
    logic [7:0]              r_data;
    logic [TIMEOUT_SIZE-1:0] r_to_cnt;
    logic                    r_rx_enable;
    logic                    r_valid;
    logic                    r_last;
    logic                    r_frame_ok;
    logic                    r_err_len;
    logic                    r_err_chk;
    logic                    r_err_timeout;
    logic [7:0]              r_buf [BUF_DEPTH];

    logic       w_framed;
    logic       w_abort;
    logic       w_strobe;
    logic       w_timeout;
    logic       w_len_bad;
    logic       w_len_err;
    logic [7:0] w_sum_chk;
    logic       w_chk_pass;
    logic       w_chk_fail;
    logic       w_pay_wr;
    logic       w_xfer;
    logic       w_load;
    logic       w_last_next;
    logic       w_unused;

    assign w_unused = i_rx_busy;

    always_comb begin
        w_framed    = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
        w_abort     = w_framed && !i_enable;
        w_strobe    = w_framed && i_enable && i_rx_valid;
        w_timeout   = w_framed && i_enable && !i_rx_valid && (r_to_cnt == TO_TERM);
        w_len_bad   = (i_rx_data == 8'h00) || (i_rx_data > MAX_LEN_B);
        w_len_err   = (r_state == S_LEN) && w_strobe && w_len_bad;
        w_sum_chk   = r_sum + i_rx_data;
        w_chk_pass  = (r_state == S_CHK) && w_strobe && (w_sum_chk == 8'h00);
        w_chk_fail  = (r_state == S_CHK) && w_strobe && (w_sum_chk != 8'h00);
        w_pay_wr    = (r_state == S_PAYLOAD) && w_strobe;
        w_xfer      = (r_state == S_DELIVER) && r_valid && i_ready;
        w_load      = w_chk_pass || (w_xfer && !r_last);
        // The first byte is fetched while the checksum strobe is accepted.
        w_rd_addr   = (r_state == S_CHK) ? '0 : r_rd + ONE;
        w_last_next = (w_rd_addr == r_len - ONE);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HUNT: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    w_state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_abort || w_timeout) begin
                    w_state_next = S_HUNT;
                end else if (w_strobe) begin
                    w_state_next = w_len_bad ? S_HUNT : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_abort || w_timeout) begin
                    w_state_next = S_HUNT;
                end else if (w_strobe && (r_idx == r_len - ONE)) begin
                    w_state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (w_abort || w_timeout) begin
                    w_state_next = S_HUNT;
                end else if (w_strobe) begin
                    w_state_next = w_chk_pass ? S_DELIVER : S_HUNT;
                end
            end
            S_DELIVER: begin
                if (w_xfer && r_last) begin
                    w_state_next = S_HUNT;
                end
            end
            default: w_state_next = S_HUNT;
        endcase
    end

    // Payload store: written only in PAYLOAD, read only in CHK/DELIVER.
    always_ff @(posedge i_clk) begin
        if (w_pay_wr) begin
            r_buf[r_idx] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_HUNT;
            r_len         <= '0;
            r_idx         <= '0;
            r_rd          <= '0;
            r_sum         <= 8'h00;
            r_data        <= 8'h00;
            r_to_cnt      <= '0;
            r_rx_enable   <= 1'b0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rx_enable   <= i_enable && (w_state_next != S_DELIVER);
            r_frame_ok    <= w_chk_pass;
            r_err_len     <= w_len_err;
            r_err_chk     <= w_chk_fail;
            r_err_timeout <= w_timeout;

            // Idle counter restarts on every byte and on every state change.
            if (w_framed && !i_rx_valid && (w_state_next == r_state)) begin
                r_to_cnt <= r_to_cnt + TIMEOUT_SIZE'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if ((r_state == S_LEN) && w_strobe) begin
                r_len <= i_rx_data[LEN_SIZE-1:0];
                r_sum <= i_rx_data;
                r_idx <= '0;
            end else if (w_pay_wr) begin
                r_sum <= w_sum_chk;
                r_idx <= r_idx + ONE;
            end

            if (w_chk_pass) begin
                r_rd <= '0;
            end else if (w_xfer) begin
                r_rd <= w_rd_addr;
            end

            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= r_buf[w_rd_addr];
                r_last  <= w_last_next;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign o_rx_enable   = r_rx_enable;
    assign o_data        = r_data;
    assign o_valid       = r_valid;
    assign o_last        = r_last;
    assign o_busy        = (r_state != S_HUNT);
    assign o_frame_ok    = r_frame_ok;
    assign o_err_len     = r_err_len;
    assign o_err_chk     = r_err_chk;
    assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames from the test plan, then random
// episodes checked against a byte-level frame parser model.
module tb_uart_rx_frame_ctrl;

    localparam int         T    = 1024;
    localparam int         MAXL = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       i_clk      = 1'b0;
    logic       i_rst_n    = 1'b1;
    logic       i_enable   = 1'b0;
    logic [7:0] i_rx_data  = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       i_rx_busy  = 1'b0;
    logic       i_ready    = 1'b0;
    logic       o_rx_enable;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       o_busy;
    logic       o_frame_ok;
    logic       o_err_len;
    logic       o_err_chk;
    logic       o_err_timeout;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE      (SYNC),
        .MAX_LEN        (MAXL),
        .LEN_SIZE       (5),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_SIZE   (11)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .i_rx_busy     (i_rx_busy),
        .o_rx_enable   (o_rx_enable),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_frame_ok    (o_frame_ok),
        .o_err_len     (o_err_len),
        .o_err_chk     (o_err_chk),
        .o_err_timeout (o_err_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;

    // Reference model: frame bytes after SYNC, time of last accepted byte, pending output.
    bit         m_in = 1'b0;
    logic [7:0] fq[$];
    int         m_last = 0;
    logic [8:0] exp_q[$];
    logic [3:0] m_pulse = 4'h0;

    bit         prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         prev_last = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] tx_q[$];
    int n_ok = 0, n_len = 0, n_cerr = 0, n_to = 0;
    int to_edge = 0, s_edge = 0;
    bit en_lvl = 1'b1;
    int rdy_mode = 0;
    bit rdy_tog = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic bit get_rdy();
        rdy_tog = ~rdy_tog;
        case (rdy_mode)
            0:       return 1'b1;
            1:       return rdy_tog;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input bit en, input bit vld, input logic [7:0] dat);
        int s;
        if (!m_in) begin
            if (vld && dat == SYNC) begin
                m_in = 1'b1;
                fq.delete();
                m_last = edge_n;
            end
        end else if (!en) begin
            m_in = 1'b0;
        end else if (vld) begin
            fq.push_back(dat);
            m_last = edge_n;
            if (fq.size() == 1) begin
                if (dat == 8'h00 || int'(dat) > MAXL) begin
                    m_pulse = 4'b0100;
                    m_in = 1'b0;
                end
            end else if (fq.size() == int'(fq[0]) + 2) begin
                s = 0;
                foreach (fq[i]) s += int'(fq[i]);
                if (s % 256 == 0) begin
                    m_pulse = 4'b1000;
                    for (int i = 1; i <= int'(fq[0]); i++)
                        exp_q.push_back({(i == int'(fq[0])), fq[i]});
                end else begin
                    m_pulse = 4'b0010;
                end
                m_in = 1'b0;
            end
        end else if (edge_n - m_last >= T - 1) begin
            m_pulse = 4'b0001;
            m_in = 1'b0;
        end
    endtask

    task automatic tick(input bit en, input bit vld, input logic [7:0] dat, input bit rdy, input bit skip);
        i_enable   = en;
        i_rx_valid = vld;
        i_rx_data  = dat;
        i_ready    = rdy;
        i_rx_busy  = 1'($urandom_range(0, 1));
        @(posedge i_clk);
        edge_n++;
        m_pulse = 4'h0;
        if (!skip) model_step(en, vld, dat);
        if (prev_valid && rdy) begin
            got_q.push_back(prev_data);
            if (exp_q.size() == 0) check("xfer_expected", exp_q.size(), 1);
            else check("xfer", {prev_last, prev_data}, exp_q.pop_front());
        end
        #1;
        check("pulses", {o_frame_ok, o_err_len, o_err_chk, o_err_timeout}, m_pulse);
        if (prev_valid && !rdy)
            check("hold", {o_valid, o_last, o_data}, {1'b1, prev_last, prev_data});
        if (o_valid) check("rx_en_deliver", o_rx_enable, 0);
        if (o_frame_ok) n_ok++;
        if (o_err_len) n_len++;
        if (o_err_chk) n_cerr++;
        if (o_err_timeout) begin
            n_to++;
            to_edge = edge_n;
        end
        prev_valid = o_valid;
        prev_data  = o_data;
        prev_last  = o_last;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        for (int i = 1; i < gap; i++) tick(en_lvl, 1'b0, 8'h00, get_rdy(), 1'b0);
        tick(en_lvl, 1'b1, b, get_rdy(), 1'b0);
        s_edge = edge_n;
    endtask

    task automatic send_q();
        while (tx_q.size() != 0) send(tx_q.pop_front(), $urandom_range(1, 3));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(en_lvl, 1'b0, 8'h00, get_rdy(), 1'b0);
    endtask

    task automatic drain();
        int k;
        bit inj;
        k = 0;
        while ((exp_q.size() != 0 || prev_valid) && k < 400) begin
            // A byte landing during delivery must be ignored entirely.
            inj = prev_valid && ($urandom_range(0, 7) == 0);
            tick(en_lvl, inj, 8'($urandom), get_rdy(), inj);
            k++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", prev_valid, 0);
        idle(2);
        check("busy", o_busy, m_in);
        check("rx_en", o_rx_enable, en_lvl);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        check("rst_async", {o_rx_enable, o_data, o_valid, o_last, o_busy,
                            o_frame_ok, o_err_len, o_err_chk, o_err_timeout}, 0);
        repeat (2) begin
            @(posedge i_clk);
            edge_n++;
        end
        #1;
        i_rst_n = 1'b1;
        m_in = 1'b0;
        exp_q.delete();
        prev_valid = 1'b0;
        prev_data = 8'h00;
        prev_last = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ok0, len0, c0, to0;
        #2;
        do_reset();
        en_lvl = 1'b1;
        idle(2);
        check("rx_en_idle", o_rx_enable, 1);

        // Good frame
        rdy_mode = 0; got_q.delete(); ok0 = n_ok;
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_q(); drain();
        check("good_ok", n_ok - ok0, 1);
        check("good_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("good_b0", got_q[0], 8'h11);
            check("good_b1", got_q[1], 8'h22);
            check("good_b2", got_q[2], 8'h33);
        end

        // Backpressure
        rdy_mode = 1; got_q.delete(); ok0 = n_ok;
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_q(); drain();
        check("bp_ok", n_ok - ok0, 1);
        check("bp_n", got_q.size(), 3);

        // Bad checksum then a good one-byte frame
        rdy_mode = 0; got_q.delete(); c0 = n_cerr;
        tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_q(); drain();
        check("chk_err", n_cerr - c0, 1);
        check("chk_nodata", got_q.size(), 0);
        tx_q = '{8'hA5, 8'h01, 8'h7F, 8'h80};
        send_q(); drain();
        check("after_chk_n", got_q.size(), 1);
        if (got_q.size() == 1) check("after_chk_b", got_q[0], 8'h7F);

        // Length errors with leading garbage
        len0 = n_len; ok0 = n_ok;
        tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'hA5, 8'h11};
        send_q(); drain();
        check("len_err", n_len - len0, 2);
        check("len_no_ok", n_ok - ok0, 0);

        // Timeout measured from the last strobe
        to0 = n_to;
        tx_q = '{8'hA5, 8'h02, 8'h55};
        send_q();
        idle(T + 4);
        check("to_cnt", n_to - to0, 1);
        check("to_delay", to_edge - s_edge, T - 1);
        check("to_busy", o_busy, 0);

        // Byte arriving exactly at terminal count keeps the frame alive
        to0 = n_to; ok0 = n_ok; got_q.delete();
        send(8'hA5, 2); send(8'h02, 1); send(8'h55, 1); send(8'h66, T - 1); send(8'h43, 1);
        drain();
        check("term_to", n_to - to0, 0);
        check("term_ok", n_ok - ok0, 1);
        check("term_n", got_q.size(), 2);

        // Reset in PAYLOAD
        tx_q = '{8'hA5, 8'h04, 8'h01};
        send_q();
        check("pay_busy", o_busy, 1);
        do_reset();
        idle(2);

        // Reset in DELIVER while the consumer stalls
        rdy_mode = 3;
        tx_q = '{8'hA5, 8'h01, 8'h42, 8'hBD};
        send_q();
        idle(2);
        check("stall_valid", o_valid, 1);
        do_reset();
        rdy_mode = 0;
        drain();

        // Enable drop in PAYLOAD aborts silently
        ok0 = n_ok; len0 = n_len; c0 = n_cerr; to0 = n_to;
        tx_q = '{8'hA5, 8'h03, 8'h01};
        send_q();
        en_lvl = 1'b0; idle(2); en_lvl = 1'b1;
        check("abort_busy", o_busy, 0);
        check("abort_pulses", (n_ok - ok0) + (n_len - len0) + (n_cerr - c0) + (n_to - to0), 0);
        drain();

        // Random episodes
        for (int ep = 0; ep < 60; ep++) begin
            int kind, len, cut, pos;
            logic [7:0] frame[$];
            logic [7:0] s, b;
            kind = $urandom_range(0, 5);
            len = $urandom_range(1, MAXL);
            rdy_mode = $urandom_range(0, 2);
            en_lvl = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send(b, $urandom_range(1, 3));
            end
            frame = '{SYNC, 8'(len)};
            s = 8'(len);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                frame.push_back(b);
                s = s + b;
            end
            frame.push_back(8'h00 - s);
            if (kind == 1) frame[frame.size() - 1] = frame[frame.size() - 1] + 8'($urandom_range(1, 255));
            if (kind == 2) frame = '{SYNC, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255))};
            cut = frame.size();
            if (kind == 3 || kind == 4) cut = $urandom_range(1, len + 2);
            pos = (kind == 5) ? $urandom_range(1, frame.size() - 1) : -1;
            for (int i = 0; i < cut; i++) send(frame[i], (i == pos) ? T - 1 : $urandom_range(1, 3));
            if (kind == 3) idle(T);
            if (kind == 4) begin
                en_lvl = 1'b0;
                idle($urandom_range(1, 3));
                en_lvl = 1'b1;
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Sequences a uart_rx instance: gates its enable, captures each received byte, and parses the byte stream into length-prefixed, checksummed frames. Frame format is SYNC, LEN, LEN payload bytes, then CHK. Good frames are buffered and delivered on a valid/ready byte stream, with o_last marking the final byte. Bad frames are dropped and reported by one-cycle error pulses. Sits between uart_rx and the command/packet consumer.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 16, maximum payload length in bytes (1..255).
LEN_SIZE, 5, width of length and index counters; must hold MAX_LEN.
TIMEOUT_CYCLES, 1024, maximum idle clocks between bytes inside a frame; must exceed one UART byte time.
TIMEOUT_SIZE, 11, width of the timeout counter.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  receive enable from system
i_rx_data  in  8  byte from uart_rx o_rxdata
i_rx_valid  in  1  one-cycle strobe from uart_rx o_recvdata
i_rx_busy  in  1  uart_rx o_busy
o_rx_enable  out  1  drives uart_rx i_enable
o_data  out  8  delivered payload byte
o_valid  out  1  o_data valid
i_ready  in  1  consumer accepts o_data
o_last  out  1  qualifies the final payload byte
o_busy  out  1  high when state is not HUNT
o_frame_ok  out  1  pulse: good frame received
o_err_len  out  1  pulse: LEN is 0 or greater than MAX_LEN
o_err_chk  out  1  pulse: checksum mismatch
o_err_timeout  out  1  pulse: inter-byte timeout

Behaviour:
- Reset (async, i_rst_n=0):
  - state=HUNT; all outputs 0; o_data=8'h00.
  - Timeout, index and sum counters cleared.
- All state and outputs are registered except o_busy, which decodes the state register.
- o_rx_enable is registered: next value = i_enable && (next state != DELIVER).
- States and transitions:
  - HUNT: on i_rx_valid with i_rx_data==SYNC_BYTE go to LEN. Any other byte is ignored.
  - LEN: on i_rx_valid, latch len and set sum=i_rx_data.
    - If i_rx_data==0 or i_rx_data>MAX_LEN: pulse o_err_len, go to HUNT.
    - Otherwise go to PAYLOAD with idx=0.
  - PAYLOAD: on i_rx_valid, write buf[idx]=i_rx_data, sum+=i_rx_data (mod 256), idx++. After byte len-1 go to CHK.
  - CHK: on i_rx_valid, test (sum+i_rx_data) mod 256.
    - If 0: pulse o_frame_ok, go to DELIVER with rd=0.
    - Else: pulse o_err_chk, go to HUNT.
  - DELIVER:
    - o_valid=1 starting the cycle after the CHK strobe.
    - o_data=buf[rd]; o_last=(rd==len-1).
    - A transfer occurs when o_valid && i_ready. On transfer rd++ and the next byte is presented the following cycle, so back-to-back transfers are allowed.
    - o_valid, o_data and o_last hold stable until accepted.
    - After the last transfer, o_valid=0, o_last=0, go to HUNT.
- Checksum rule: CHK = two's complement of (LEN + sum of payload) mod 256, so that LEN+payload+CHK ≡ 0 mod 256.
- Timeout:
  - The counter runs only in LEN, PAYLOAD and CHK, and clears on every i_rx_valid and on entry to those states.
  - When it reaches TIMEOUT_CYCLES-1 without a strobe: pulse o_err_timeout, go to HUNT.
  - i_rx_valid in the same cycle as terminal count: the byte wins, no timeout.
- i_enable low while in LEN, PAYLOAD or CHK: abort to HUNT next cycle, no error pulse.
- i_enable low in DELIVER: delivery completes normally.
- i_rx_valid in DELIVER (byte already in flight when enable dropped) is discarded. The buffer is not disturbed.
- i_rx_busy is status only. It has no effect on transitions.
- Error and ok pulses are exactly one cycle wide and mutually exclusive.
- Reset mid-frame or mid-delivery returns to HUNT immediately; buffered data is discarded.

Test Plan:
- Good frame: i_enable=1, bytes A5 03 11 22 33 97 → o_frame_ok pulse once. Then 11, 22, 33 delivered, o_last only on 33. o_rx_enable=0 during DELIVER and back to 1 after.
- Backpressure: same frame with i_ready toggling 0/1 each cycle → each byte held stable while i_ready=0, exactly 3 transfers, no duplicates or losses.
- Bad checksum: A5 02 10 20 00 → o_err_chk pulse, no o_valid, state HUNT. Following good frame A5 01 7F 80 → delivers 7F.
- Length errors: A5 00, and A5 11 with MAX_LEN=16 → o_err_len pulse each; garbage 00 FF 5A before A5 is ignored.
- Timeout: A5 02 55 then silence → o_err_timeout exactly TIMEOUT_CYCLES-1 cycles after the 55 strobe. With a strobe at terminal count, no timeout fires.
- Reset/enable: assert i_rst_n=0 in PAYLOAD and in DELIVER → all outputs 0 asynchronously. Drop i_enable in PAYLOAD → HUNT with no error pulse.
